// File: rtl/redmule_pkg.sv
// Shared types, sizes and helpers for the RedMulE Z drain (store side of the Z buffer).
package redmule_pkg;

  localparam int unsigned DATA_W      = 256;
  localparam int unsigned BITW        = 16;
  localparam int unsigned ARRAY_WIDTH = 12;
  localparam int unsigned TOT_DEPTH   = DATA_W / BITW;
  localparam int unsigned STRB        = DATA_W / 8;
  localparam int unsigned ITER_W      = 16;
  localparam int unsigned ROW_CNT_W   = $clog2(ARRAY_WIDTH);
  localparam int unsigned ROWS_LFT_W  = $clog2(ARRAY_WIDTH) + 1;
  localparam int unsigned COLS_LFT_W  = $clog2(TOT_DEPTH) + 1;
  localparam int unsigned NSTORE_W    = 16;

  typedef enum logic [1:0] {
    ZD_IDLE  = 2'd0,
    ZD_DRAIN = 2'd1,
    ZD_FLUSH = 2'd2
  } z_drain_state_e;

  typedef struct packed {
    logic                  start;
    logic [ITER_W-1:0]     x_row_iters;
    logic [ITER_W-1:0]     w_col_iters;
    logic [ROWS_LFT_W-1:0] rows_lftovr;
    logic [COLS_LFT_W-1:0] cols_lftovr;
  } z_drain_ctrl_t;

  typedef struct packed {
    logic stored;
    logic done;
    logic busy;
  } z_drain_flgs_t;

  // Byte strobes for the last column tile: low cols_lftovr elements enabled, 0 means full.
  function automatic logic [STRB-1:0] strb_mask(input logic [COLS_LFT_W-1:0] cols_lftovr);
    logic [STRB-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < STRB; i++) begin
      m[i] = (cols_lftovr == '0) || (i < (32'(cols_lftovr) * BITW / 8));
    end
    return m;
  endfunction

endpackage

// File: rtl/redmule_z_drain.sv
// Drains accumulated Z rows tile by tile into the store stream, dropping rows past the
// row leftover and masking bytes past the column leftover; reports stored/done/busy.
module redmule_z_drain
  import redmule_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ITER_W-1:0]     x_row_iters_i,
  input  logic [ITER_W-1:0]     w_col_iters_i,
  input  logic [ROWS_LFT_W-1:0] rows_lftovr_i,
  input  logic [COLS_LFT_W-1:0] cols_lftovr_i,
  input  logic                  row_valid_i,
  input  logic [DATA_W-1:0]     row_data_i,
  output logic                  row_ready_o,
  output logic                  z_valid_o,
  output logic [DATA_W-1:0]     z_data_o,
  output logic [STRB-1:0]       z_strb_o,
  input  logic                  z_ready_i,
  output logic                  stored_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [NSTORE_W-1:0]   n_stores_o
);

  z_drain_state_e state_q, state_d;

  logic [ITER_W-1:0]     x_iters_q, x_iters_d;
  logic [ITER_W-1:0]     w_iters_q, w_iters_d;
  logic [ROWS_LFT_W-1:0] rows_lft_q, rows_lft_d;
  logic [COLS_LFT_W-1:0] cols_lft_q, cols_lft_d;

  logic [ROW_CNT_W-1:0]  r_q, r_d;
  logic [ITER_W-1:0]     c_q, c_d;
  logic [ITER_W-1:0]     t_q, t_d;

  logic                  z_valid_q, z_valid_d;
  logic [DATA_W-1:0]     z_data_q, z_data_d;
  logic [STRB-1:0]       z_strb_q, z_strb_d;
  logic [NSTORE_W-1:0]   n_stores_q, n_stores_d;
  z_drain_flgs_t         flgs_q, flgs_d;

  logic row_hs_c;
  logic z_hs_c;
  logic last_r_c;
  logic last_c_c;
  logic last_t_c;
  logic keep_c;

  // Single output register: a new row may be taken only when the register is empty or emptying.
  assign row_ready_o = (state_q == ZD_DRAIN) && (!z_valid_q || z_ready_i);
  assign row_hs_c    = row_valid_i && row_ready_o;
  assign z_hs_c      = z_valid_q && z_ready_i;

  assign last_r_c = (r_q == ROW_CNT_W'(ARRAY_WIDTH - 1));
  assign last_c_c = (c_q == (w_iters_q - ITER_W'(1)));
  assign last_t_c = (t_q == (x_iters_q - ITER_W'(1)));
  assign keep_c   = !(last_t_c && (rows_lft_q != '0) && (ROWS_LFT_W'(r_q) >= rows_lft_q));

  always_comb begin
    state_d    = state_q;
    x_iters_d  = x_iters_q;
    w_iters_d  = w_iters_q;
    rows_lft_d = rows_lft_q;
    cols_lft_d = cols_lft_q;
    r_d        = r_q;
    c_d        = c_q;
    t_d        = t_q;
    z_valid_d  = z_valid_q;
    z_data_d   = z_data_q;
    z_strb_d   = z_strb_q;
    n_stores_d = n_stores_q;
    flgs_d     = '0;

    // Output handshake retires the register; a same-cycle load below re-arms it.
    if (z_hs_c) begin
      z_valid_d     = 1'b0;
      flgs_d.stored = 1'b1;
      if (n_stores_q != {NSTORE_W{1'b1}}) begin
        n_stores_d = n_stores_q + NSTORE_W'(1);
      end
    end

    unique case (state_q)
      ZD_IDLE: begin
        if (start_i) begin
          x_iters_d  = x_row_iters_i;
          w_iters_d  = w_col_iters_i;
          rows_lft_d = rows_lftovr_i;
          cols_lft_d = cols_lftovr_i;
          r_d        = '0;
          c_d        = '0;
          t_d        = '0;
          n_stores_d = '0;
          state_d    = ZD_DRAIN;
        end
      end

      ZD_DRAIN: begin
        if (row_hs_c) begin
          if (keep_c) begin
            z_valid_d = 1'b1;
            z_data_d  = row_data_i;
            z_strb_d  = (last_c_c) ? strb_mask(cols_lft_q) : {STRB{1'b1}};
          end
          if (last_r_c) begin
            r_d = '0;
            if (last_c_c) begin
              c_d = '0;
              t_d = t_q + ITER_W'(1);
            end else begin
              c_d = c_q + ITER_W'(1);
            end
          end else begin
            r_d = r_q + ROW_CNT_W'(1);
          end
          if (last_r_c && last_c_c && last_t_c) begin
            state_d = ZD_FLUSH;
          end
        end
      end

      ZD_FLUSH: begin
        if (!z_valid_q || z_hs_c) begin
          flgs_d.done = 1'b1;
          state_d     = ZD_IDLE;
        end
      end

      default: begin
        state_d = ZD_IDLE;
      end
    endcase

    flgs_d.busy = (state_d != ZD_IDLE);
  end

  // State and datapath registers; clear behaves exactly like reset and drops any pending row.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= ZD_IDLE;
      x_iters_q  <= '0;
      w_iters_q  <= '0;
      rows_lft_q <= '0;
      cols_lft_q <= '0;
      r_q        <= '0;
      c_q        <= '0;
      t_q        <= '0;
      z_valid_q  <= 1'b0;
      z_data_q   <= '0;
      z_strb_q   <= '0;
      n_stores_q <= '0;
      flgs_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_iters_q  <= x_iters_d;
      w_iters_q  <= w_iters_d;
      rows_lft_q <= rows_lft_d;
      cols_lft_q <= cols_lft_d;
      r_q        <= r_d;
      c_q        <= c_d;
      t_q        <= t_d;
      z_valid_q  <= z_valid_d;
      z_data_q   <= z_data_d;
      z_strb_q   <= z_strb_d;
      n_stores_q <= n_stores_d;
      flgs_q     <= flgs_d;
    end
  end

  assign z_valid_o  = z_valid_q;
  assign z_data_o   = z_data_q;
  assign z_strb_o   = z_strb_q;
  assign n_stores_o = n_stores_q;
  assign stored_o   = flgs_q.stored;
  assign done_o     = flgs_q.done;
  assign busy_o     = flgs_q.busy;

endmodule

// File: tb/tb_redmule_z_drain.sv
// Directed bench for redmule_z_drain: full/partial tiles, backpressure, mid-job reset, ignored restart.
module tb_redmule_z_drain;

  logic         clk_i;
  logic         rst_i;
  logic         clear_i;
  logic         start_i;
  logic [15:0]  x_row_iters_i;
  logic [15:0]  w_col_iters_i;
  logic [4:0]   rows_lftovr_i;
  logic [4:0]   cols_lftovr_i;
  logic         row_valid_i;
  logic [255:0] row_data_i;
  logic         row_ready_o;
  logic         z_valid_o;
  logic [255:0] z_data_o;
  logic [31:0]  z_strb_o;
  logic         z_ready_i;
  logic         stored_o;
  logic         done_o;
  logic         busy_o;
  logic [15:0]  n_stores_o;

  int n_checks;
  int n_fails;

  redmule_z_drain dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .x_row_iters_i (x_row_iters_i),
    .w_col_iters_i (w_col_iters_i),
    .rows_lftovr_i (rows_lftovr_i),
    .cols_lftovr_i (cols_lftovr_i),
    .row_valid_i   (row_valid_i),
    .row_data_i    (row_data_i),
    .row_ready_o   (row_ready_o),
    .z_valid_o     (z_valid_o),
    .z_data_o      (z_data_o),
    .z_strb_o      (z_strb_o),
    .z_ready_i     (z_ready_i),
    .stored_o      (stored_o),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .n_stores_o    (n_stores_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_row(input int idx);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'(idx) ^ (32'(idx) << 20);
    return {8{w}};
  endfunction

  // Hand-written strobe expectation: 2 bytes per fp16 element
  function automatic logic [31:0] exp_strb(input int c, input int wi, input int cl);
    logic [63:0] m;
    if (c == wi - 1 && cl != 0) begin
      m = (64'd1 << (2 * cl)) - 64'd1;
      return m[31:0];
    end
    return 32'hFFFF_FFFF;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"},  256'(z_valid_o),   256'd0);
    check_eq({tag, "_data"},   z_data_o,          256'd0);
    check_eq({tag, "_strb"},   256'(z_strb_o),    256'd0);
    check_eq({tag, "_rready"}, 256'(row_ready_o), 256'd0);
    check_eq({tag, "_stored"}, 256'(stored_o),    256'd0);
    check_eq({tag, "_done"},   256'(done_o),      256'd0);
    check_eq({tag, "_busy"},   256'(busy_o),      256'd0);
    check_eq({tag, "_nst"},    256'(n_stores_o),  256'd0);
  endtask

  // Runs one job end to end with a Z-buffer feeder and store-side monitor.
  task automatic run_job(input string tag, input int xi, input int wi, input int rl, input int cl,
                         input bit rnd, input int restart_at, input bit chk_lat);
    int total, sent, nout, nst, ndone, cyc, last_hs, done_cyc;
    int kept[$];
    bit prev_stall;
    logic [255:0] pd;
    logic [31:0] ps;
    total = 12 * xi * wi;
    for (int i = 0; i < total; i++) begin
      int r, t;
      r = i % 12;
      t = i / (12 * wi);
      if (!(t == xi - 1 && rl != 0 && r >= rl)) kept.push_back(i);
    end
    sent = 0; nout = 0; nst = 0; ndone = 0; cyc = 0; last_hs = -10; done_cyc = -1;
    prev_stall = 1'b0; pd = '0; ps = '0;
    x_row_iters_i = 16'(xi);
    w_col_iters_i = 16'(wi);
    rows_lftovr_i = 5'(rl);
    cols_lftovr_i = 5'(cl);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    while (ndone == 0 && cyc < 3000) begin
      row_valid_i = (sent < total);
      row_data_i  = mk_row(sent);
      z_ready_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_i     = (cyc == restart_at);
      if (cyc == restart_at) begin
        x_row_iters_i = 16'd7;
        w_col_iters_i = 16'd3;
        rows_lftovr_i = 5'd1;
      end
      @(negedge clk_i);
      if (prev_stall) begin
        check_eq({tag, "_hold_valid"}, 256'(z_valid_o), 256'd1);
        check_eq({tag, "_hold_data"}, z_data_o, pd);
        check_eq({tag, "_hold_strb"}, 256'(z_strb_o), 256'(ps));
      end
      prev_stall = z_valid_o && !z_ready_i;
      if (prev_stall) begin
        check_eq({tag, "_rready_stall"}, 256'(row_ready_o), 256'd0);
        pd = z_data_o;
        ps = z_strb_o;
      end
      if (z_valid_o && z_ready_i) begin
        if (nout < kept.size()) begin
          int k;
          k = kept[nout];
          check_eq({tag, "_data"}, z_data_o, mk_row(k));
          check_eq({tag, "_strb"}, 256'(z_strb_o), 256'(exp_strb((k / 12) % wi, wi, cl)));
        end
        nout++;
        last_hs = cyc;
      end
      if (row_valid_i && row_ready_o) sent++;
      if (stored_o) nst++;
      if (done_o) begin
        ndone++;
        done_cyc = cyc;
      end
      step();
      cyc++;
    end
    start_i     = 1'b0;
    row_valid_i = 1'b0;
    z_ready_i   = 1'b1;
    if (ndone == 0) $display("FAIL %s_timeout: got no done_o after %0d cycles expected done", tag, cyc);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (done_o) ndone++;
      if (stored_o) nst++;
      if (z_valid_o) nout++;
      step();
    end
    check_eq({tag, "_ndone"},    256'(ndone),      256'd1);
    check_eq({tag, "_consumed"}, 256'(sent),       256'(total));
    check_eq({tag, "_nout"},     256'(nout),       256'(kept.size()));
    check_eq({tag, "_nstored"},  256'(nst),        256'(kept.size()));
    check_eq({tag, "_nstores"},  256'(n_stores_o), 256'(kept.size()));
    check_eq({tag, "_busy_end"}, 256'(busy_o),     256'd0);
    if (chk_lat) check_eq({tag, "_done_lat"}, 256'(done_cyc - last_hs), 256'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
    x_row_iters_i = 16'd1; w_col_iters_i = 16'd1;
    rows_lftovr_i = '0; cols_lftovr_i = '0;
    row_valid_i = 1'b0; row_data_i = '0; z_ready_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("reset");
    step();

    run_job("full",    1, 1, 0, 0, 1'b0, -1, 1'b1);
    // Last column tile keeps 5 elements: strobe 32'h000003FF
    check_eq("strb_table5", 256'(exp_strb(1, 2, 5)), 256'h3FF);
    run_job("colleft", 1, 2, 0, 5, 1'b0, -1, 1'b1);
    run_job("rowleft", 2, 1, 3, 0, 1'b0, -1, 1'b0);
    run_job("backpr",  2, 2, 5, 7, 1'b1, -1, 1'b0);

    // Reset in the middle of a job: abort with no done_o
    x_row_iters_i = 16'd1; w_col_iters_i = 16'd1;
    rows_lftovr_i = '0; cols_lftovr_i = '0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    begin
      int sent, cyc;
      sent = 0; cyc = 0;
      while (sent < 5 && cyc < 100) begin
        row_valid_i = 1'b1;
        row_data_i  = mk_row(sent);
        @(negedge clk_i);
        if (row_ready_o) sent++;
        step();
        cyc++;
      end
      check_eq("rst_mid_sent", 256'(sent), 256'd5);
    end
    row_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("rst_mid");
    step();
    run_job("after_rst", 1, 1, 0, 0, 1'b0, -1, 1'b1);

    run_job("restart", 1, 1, 0, 0, 1'b0, 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
